// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall controller.
// Tnew/Tuse are 2-bit unsigned cycle counts.
package stall_ctrl_pkg;

   typedef enum logic [1:0] {
      TUSE_0 = 2'd0,
      TUSE_1 = 2'd1,
      TUSE_2 = 2'd2
   } tuse_e;

   typedef enum logic [1:0] {
      TNEW_0 = 2'd0,
      TNEW_1 = 2'd1,
      TNEW_2 = 2'd2
   } tnew_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   // A producer in flight conflicts only if its result arrives later than the consumer needs it.
   function automatic logic prod_conflict(input logic [4:0] src, input logic we,
                                          input logic [4:0] dst, input logic [1:0] tnew,
                                          input logic [1:0] tuse);
      return we && (dst == src) && (tnew > tuse);
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy countdown: loads the operation latency on start, then counts to zero.
module md_busy_counter
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic start_i,
   input  logic is_div_i,
   output logic busy_o
);

   localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;

   logic [CntW-1:0] md_cnt_q, md_cnt_d;

   // Start has priority so a new operation reloads an in-progress countdown.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (start_i) begin
         md_cnt_d = is_div_i ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard controller: stalls PC and F/D and flushes D/E on Tuse/Tnew and mult/div hazards,
// and counts stalled cycles with a saturating counter.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_rs_number,
   input  logic [4:0]       D_rt_number,
   input  logic             D_rs_use,
   input  logic             D_rt_use,
   input  logic [1:0]       D_rs_tuse,
   input  logic [1:0]       D_rt_tuse,
   input  logic             D_md_use,
   input  logic [4:0]       E_REG_write_number,
   input  logic             E_REG_write_enable,
   input  logic [1:0]       E_tnew,
   input  logic [4:0]       M_REG_write_number,
   input  logic             M_REG_write_enable,
   input  logic [1:0]       M_tnew,
   input  logic             E_md_start,
   input  logic             E_md_is_div,
   output logic             stall,
   output logic             DE_flush,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   logic hz_rs, hz_rt, hz_md;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_counter (
      .clk_i    (clk),
      .reset_i  (reset),
      .start_i  (E_md_start),
      .is_div_i (E_md_is_div),
      .busy_o   (md_busy)
   );

   // $0 never carries a real dependency.
   always_comb begin
      hz_rs = D_rs_use && (D_rs_number != 5'd0) &&
              (prod_conflict(D_rs_number, E_REG_write_enable, E_REG_write_number, E_tnew,
                             D_rs_tuse) ||
               prod_conflict(D_rs_number, M_REG_write_enable, M_REG_write_number, M_tnew,
                             D_rs_tuse));
      hz_rt = D_rt_use && (D_rt_number != 5'd0) &&
              (prod_conflict(D_rt_number, E_REG_write_enable, E_REG_write_number, E_tnew,
                             D_rt_tuse) ||
               prod_conflict(D_rt_number, M_REG_write_enable, M_REG_write_number, M_tnew,
                             D_rt_tuse));
      hz_md = D_md_use && (E_md_start || md_busy);
      stall    = !reset && (hz_rs || hz_rt || hz_md);
      DE_flush = stall;
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: table of hazard vectors plus mult/div, reset and saturation runs.
module tb_stall_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] D_rs_number, D_rt_number, E_REG_write_number, M_REG_write_number;
   logic D_rs_use, D_rt_use, D_md_use, E_REG_write_enable, M_REG_write_enable;
   logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
   logic E_md_start, E_md_is_div;
   logic stall, DE_flush, md_busy;
   logic [31:0] stall_count;
   logic stall4, flush4, busy4;
   logic [3:0] stall_count4;

   int n_vec = 0;
   int n_err = 0;
   int exp32 = 0;
   int exp4 = 0;

   always #5 clk = ~clk;

   stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .D_rs_number(D_rs_number), .D_rt_number(D_rt_number),
      .D_rs_use(D_rs_use), .D_rt_use(D_rt_use),
      .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_md_use(D_md_use),
      .E_REG_write_number(E_REG_write_number), .E_REG_write_enable(E_REG_write_enable),
      .E_tnew(E_tnew),
      .M_REG_write_number(M_REG_write_number), .M_REG_write_enable(M_REG_write_enable),
      .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
      .stall(stall), .DE_flush(DE_flush), .md_busy(md_busy), .stall_count(stall_count)
   );

   stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .D_rs_number(D_rs_number), .D_rt_number(D_rt_number),
      .D_rs_use(D_rs_use), .D_rt_use(D_rt_use),
      .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_md_use(D_md_use),
      .E_REG_write_number(E_REG_write_number), .E_REG_write_enable(E_REG_write_enable),
      .E_tnew(E_tnew),
      .M_REG_write_number(M_REG_write_number), .M_REG_write_enable(M_REG_write_enable),
      .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
      .stall(stall4), .DE_flush(flush4), .md_busy(busy4), .stall_count(stall_count4)
   );

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rs_use;
      logic       rt_use;
      logic [1:0] rs_tuse;
      logic [1:0] rt_tuse;
      logic       md_use;
      logic [4:0] e_num;
      logic       e_we;
      logic [1:0] e_tnew;
      logic [4:0] m_num;
      logic       m_we;
      logic [1:0] m_tnew;
      logic       exp_stall;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      D_rs_number = 5'd0; D_rt_number = 5'd0; D_rs_use = 1'b0; D_rt_use = 1'b0;
      D_rs_tuse = 2'd0; D_rt_tuse = 2'd0; D_md_use = 1'b0;
      E_REG_write_number = 5'd0; E_REG_write_enable = 1'b0; E_tnew = 2'd0;
      M_REG_write_number = 5'd0; M_REG_write_enable = 1'b0; M_tnew = 2'd0;
      E_md_start = 1'b0; E_md_is_div = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      D_rs_number = v.rs; D_rt_number = v.rt; D_rs_use = v.rs_use; D_rt_use = v.rt_use;
      D_rs_tuse = v.rs_tuse; D_rt_tuse = v.rt_tuse; D_md_use = v.md_use;
      E_REG_write_number = v.e_num; E_REG_write_enable = v.e_we; E_tnew = v.e_tnew;
      M_REG_write_number = v.m_num; M_REG_write_enable = v.m_we; M_tnew = v.m_tnew;
   endtask

   // Advance one edge; st is the stall expected during the cycle just ending.
   task automatic step(input logic st);
      @(posedge clk);
      #1;
      if (reset) begin
         exp32 = 0;
         exp4 = 0;
      end else if (st) begin
         exp32++;
         if (exp4 != 15) exp4++;
      end
   endtask

   task automatic run_md(input logic is_div, input int n);
      clear_inputs();
      D_md_use = 1'b1;
      E_md_start = 1'b1;
      E_md_is_div = is_div;
      for (int i = 0; i <= n + 1; i++) begin
         #1;
         chk($sformatf("md%0d stall c%0d", n, i), stall, (i <= n));
         chk($sformatf("md%0d flush c%0d", n, i), DE_flush, (i <= n));
         chk($sformatf("md%0d busy c%0d", n, i), md_busy, (i >= 1 && i <= n));
         step(i <= n);
         E_md_start = 1'b0;
      end
      chk($sformatf("md%0d stall_count", n), stall_count, exp32);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      //          rs    rt    rsu   rtu   rsT   rtT   md    eN    eWe   eTn   mN    mWe   mTn   st
      vecs[0]  = '{5'd1, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 5'd1, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
      vecs[1]  = '{5'd1, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd1, 1'b1, 2'd1, 1'b0};
      vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd1, 1'b1};
      vecs[4]  = '{5'd0, 5'd5, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0, 1'b0};
      vecs[5]  = '{5'd3, 5'd0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 5'd3, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[6]  = '{5'd3, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 5'd3, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1};
      vecs[7]  = '{5'd3, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd3, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[8]  = '{5'd3, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 5'd3, 1'b0, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 5'd4, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[10] = '{5'd0, 5'd7, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
      vecs[11] = '{5'd0, 5'd7, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0};
      vecs[13] = '{5'd9, 5'd9, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 5'd9, 1'b1, 2'd2, 5'd9, 1'b1, 2'd1, 1'b0};
      vecs[14] = '{5'd0, 5'd6, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd6, 1'b0, 2'd1, 1'b0};

      // Reset with a live hazard on the inputs: outputs must stay quiet.
      clear_inputs();
      reset = 1'b1;
      apply(vecs[0]);
      step(1'b0);
      step(1'b0);
      #1;
      chk("reset stall", stall, 0);
      chk("reset flush", DE_flush, 0);
      chk("reset md_busy", md_busy, 0);
      chk("reset stall_count", stall_count, 0);
      reset = 1'b0;
      clear_inputs();
      step(1'b0);

      // Table vectors; 0 followed by 1 is the lw-then-use sequence.
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d stall", i), stall, vecs[i].exp_stall);
         chk($sformatf("vec%0d flush", i), DE_flush, vecs[i].exp_stall);
         step(vecs[i].exp_stall);
         chk($sformatf("vec%0d stall_count", i), stall_count, exp32);
      end

      run_md(1'b0, 5);
      run_md(1'b1, 10);

      // Reset mid-division when the countdown reaches 7.
      clear_inputs();
      D_md_use = 1'b1;
      E_md_start = 1'b1;
      E_md_is_div = 1'b1;
      #1;
      chk("rstdiv start stall", stall, 1);
      step(1'b1);
      E_md_start = 1'b0;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("rstdiv busy at 7", md_busy, 1);
      reset = 1'b1;
      #1;
      chk("rstdiv stall in reset", stall, 0);
      chk("rstdiv flush in reset", DE_flush, 0);
      step(1'b0);
      chk("rstdiv md_busy", md_busy, 0);
      chk("rstdiv stall_count", stall_count, 0);
      chk("rstdiv stall_count4", {28'd0, stall_count4}, 0);
      reset = 1'b0;
      #1;
      chk("rstdiv stall after", stall, 0);

      // Hold a hazard for 20 cycles; the 4-bit counter must stick at 15.
      clear_inputs();
      apply(vecs[0]);
      for (int i = 1; i <= 20; i++) begin
         step(1'b1);
         chk($sformatf("sat4 c%0d", i), {28'd0, stall_count4}, exp4);
         chk($sformatf("sat32 c%0d", i), stall_count, exp32);
      end
      chk("sat4 final", {28'd0, stall_count4}, 15);
      chk("sat4 stall", stall4, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
